fft_tx_serializer: RTL and testbench



---
 rtl/fft_tx_serializer_if.sv | 26 ++
 rtl/fft_tx_serializer.sv | 132 +++++++++++++
 tb/tb_fft_tx_serializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_tx_serializer_if.sv
// Handshake bundle between the FFT core, fft_tx_serializer and the UART transmitter.
// master: the serializer side; slave: the FFT/UART environment side.
interface fft_tx_serializer_if #(
    parameter int unsigned FFT_SIZE    = 32,
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned DATA_LENGTH = 8
);
    logic [FFT_SIZE*WORD_SIZE-1:0] i_fft_re;
    logic                          i_FFT32_cycle_done;
    logic                          i_TX_done;
    logic                          o_TX_start;
    logic [DATA_LENGTH-1:0]        o_TX_byte;
    logic                          o_busy;
    logic                          o_frame_done;
    logic                          o_overrun;

    modport master (
        input  i_fft_re, i_FFT32_cycle_done, i_TX_done,
        output o_TX_start, o_TX_byte, o_busy, o_frame_done, o_overrun
    );

    modport slave (
        output i_fft_re, i_FFT32_cycle_done, i_TX_done,
        input  o_TX_start, o_TX_byte, o_busy, o_frame_done, o_overrun
    );
endinterface

// File: rtl/fft_tx_serializer.sv
// Snapshots one FFT frame and streams it to the UART TX, bin 0 first, low byte first.
// Define FFT_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module fft_tx_serializer #(
    parameter int unsigned FFT_SIZE    = 32,
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned DATA_LENGTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fft_tx_serializer_if.master bus
);
    localparam int unsigned IDX_W  = $clog2(2 * FFT_SIZE + 1);
    localparam int unsigned WIDX_W = (FFT_SIZE > 1) ? $clog2(FFT_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * FFT_SIZE - 1);
`ifdef FFT_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CHK_IDX = IDX_W'(2 * FFT_SIZE);
`endif

    typedef enum logic [2:0] {StIdle, StStart, StWait, StLast, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_SIZE-1:0]   snap_q [FFT_SIZE];
    logic                   load;
    logic                   cd_q;
    logic [WORD_SIZE-1:0]   cur_word;
    logic [DATA_LENGTH-1:0] cur_byte;
`ifdef FFT_TX_CHECKSUM_EN
    logic [DATA_LENGTH-1:0] chk_q, chk_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_FFT32_cycle_done) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (bus.i_TX_done) begin
                    if (idx_q == LAST_IDX) begin
`ifdef FFT_TX_CHECKSUM_EN
                        state_d = StLast;
`else
                        state_d = StDone;
`endif
                    end
`ifdef FFT_TX_CHECKSUM_EN
                    else if (idx_q == CHK_IDX) begin
                        state_d = StDone;
                    end
`endif
                    else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StStart;
                    end
                end
            end
            StLast: begin
`ifdef FFT_TX_CHECKSUM_EN
                idx_d   = CHK_IDX;
                state_d = StStart;
`else
                state_d = StDone;
`endif
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // idx[0] picks the half of the word; the checksum slot reuses word 0 harmlessly.
    always_comb begin
        cur_word = snap_q[idx_q[WIDX_W:1]];
        cur_byte = idx_q[0] ? cur_word[WORD_SIZE-1 -: DATA_LENGTH] : cur_word[DATA_LENGTH-1:0];
`ifdef FFT_TX_CHECKSUM_EN
        if (idx_q == CHK_IDX) begin
            cur_byte = chk_q;
        end
`endif
    end

`ifdef FFT_TX_CHECKSUM_EN
    always_comb begin
        chk_d = chk_q;
        if (load) begin
            chk_d = '0;
        end else if (state_q == StWait && bus.i_TX_done && idx_q != CHK_IDX) begin
            chk_d = chk_q ^ cur_byte;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cd_q    <= 1'b0;
            for (int k = 0; k < int'(FFT_SIZE); k++) begin
                snap_q[k] <= '0;
            end
`ifdef FFT_TX_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cd_q    <= bus.i_FFT32_cycle_done;
            if (load) begin
                for (int k = 0; k < int'(FFT_SIZE); k++) begin
                    snap_q[k] <= bus.i_fft_re[k*WORD_SIZE +: WORD_SIZE];
                end
            end
`ifdef FFT_TX_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Overrun flags only the rising edge of cycle_done while a frame is in flight.
    assign bus.o_TX_start   = (state_q == StStart);
    assign bus.o_TX_byte    = cur_byte;
    assign bus.o_busy       = (state_q != StIdle);
    assign bus.o_frame_done = (state_q == StDone);
    assign bus.o_overrun    = (state_q != StIdle) && bus.i_FFT32_cycle_done && !cd_q;
endmodule

// File: tb/tb_fft_tx_serializer.sv
// Scoreboard bench for fft_tx_serializer: expected bytes are queued at frame launch and
// popped by a monitor on every TX start.
module tb_fft_tx_serializer;
    localparam int FFT = 32;
`ifdef FFT_TX_CHECKSUM_EN
    localparam int FRAME_BYTES = 2 * FFT + 1;
    localparam int FD_LAT      = 132;
`else
    localparam int FRAME_BYTES = 2 * FFT;
    localparam int FD_LAT      = 129;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx_done_m = 1'b0;
    logic tx_spur   = 1'b0;
    logic tx_en     = 1'b1;
    int   ack_delay = 3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_starts = 0, n_fd = 0, n_ovr = 0;
    int last_ack_cyc = 0, fd_cyc = 0;
    int base_starts, base_fd, base_ovr, c0;
    logic [7:0] exp_q [$];

    fft_tx_serializer_if #(.FFT_SIZE(FFT), .WORD_SIZE(16), .DATA_LENGTH(8)) bus ();

    fft_tx_serializer #(.FFT_SIZE(FFT), .WORD_SIZE(16), .DATA_LENGTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign bus.i_TX_done = tx_done_m | tx_spur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bin_val(input int mode, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        case (mode)
            0:       return {kb, kb};
            1:       return {kb, 8'hFF - kb};
            2:       return (k == 0) ? 16'h00A5 : ((k == 1) ? 16'h005A : 16'h0000);
            default: return 16'hDEAD ^ {8'h00, kb};
        endcase
    endfunction

    task automatic apply_bins(input int mode);
        for (int k = 0; k < FFT; k++) bus.i_fft_re[k*16 +: 16] = bin_val(mode, k);
    endtask

    task automatic push_frame(input int mode);
        logic [15:0] w;
        logic [7:0]  chk;
        chk = 8'h00;
        for (int k = 0; k < FFT; k++) begin
            w = bin_val(mode, k);
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            chk = chk ^ w[7:0] ^ w[15:8];
        end
`ifdef FFT_TX_CHECKSUM_EN
        exp_q.push_back(chk);
`endif
    endtask

    // Launches a frame with a one-cycle cycle_done pulse; returns in the START cycle.
    task automatic start_frame(input int mode);
        apply_bins(mode);
        push_frame(mode);
        base_starts = n_starts;
        base_fd     = n_fd;
        base_ovr    = n_ovr;
        bus.i_FFT32_cycle_done = 1'b1;
        c0 = cyc;
        tick();
        bus.i_FFT32_cycle_done = 1'b0;
        @(negedge clk);
        check("busy_after_cd", int'(bus.o_busy), 1);
        check("start_after_cd", int'(bus.o_TX_start), 1);
        check("no_overrun_on_launch", int'(bus.o_overrun), 0);
    endtask

    task automatic wait_starts(input int n, input int limit);
        for (int i = 0; i < limit && (n_starts - base_starts) < n; i++) tick();
        check("starts_reached", int'((n_starts - base_starts) >= n), 1);
    endtask

    task automatic wait_fd(input int limit);
        for (int i = 0; i < limit && n_fd == base_fd; i++) tick();
        check("frame_done_seen", n_fd - base_fd, 1);
        repeat (3) tick();
        check("frame_done_once", n_fd - base_fd, 1);
        check("frame_bytes", n_starts - base_starts, FRAME_BYTES);
        check("idle_after_frame", int'(bus.o_busy), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_start"}, int'(bus.o_TX_start), 0);
        check({tag, "_byte"}, int'(bus.o_TX_byte), 0);
        check({tag, "_busy"}, int'(bus.o_busy), 0);
        check({tag, "_frame_done"}, int'(bus.o_frame_done), 0);
        check({tag, "_overrun"}, int'(bus.o_overrun), 0);
    endtask

    // UART TX model: acknowledge each start ack_delay cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_TX_start && tx_en) begin
                repeat (ack_delay) @(posedge clk);
                #1 tx_done_m = 1'b1;
                @(posedge clk);
                #1 tx_done_m = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.i_TX_done && bus.o_busy) last_ack_cyc = cyc;
            if (bus.o_TX_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", int'(bus.o_TX_byte), int'(e));
                end
            end
            if (bus.o_frame_done) begin
                n_fd++;
                fd_cyc = cyc;
                check("fd_one_after_last_ack", cyc, last_ack_cyc + 1);
                check("fd_all_bytes_sent", exp_q.size(), 0);
            end
            if (bus.o_overrun) n_ovr++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, f0;
        rst = 1'b1;
        bus.i_FFT32_cycle_done = 1'b0;
        apply_bins(0);
        tick();
        tick();
        @(negedge clk);
        check_outputs_zero("reset");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Ramp frame, slow acks, overrun pulse at byte 10 with new data on the bus.
        ack_delay = 3;
        start_frame(0);
        wait_starts(10, 200);
        apply_bins(3);
        bus.i_FFT32_cycle_done = 1'b1;
        tick();
        bus.i_FFT32_cycle_done = 1'b0;
        wait_fd(2000);
        check("overrun_pulses", n_ovr - base_ovr, 1);

        // Immediate acks: start every other cycle, fixed frame latency.
        ack_delay = 1;
        start_frame(1);
        wait_fd(1000);
        check("fd_latency_fast_ack", fd_cyc - c0, FD_LAT);

        // Spurious TX_done in IDLE and in START must not advance.
        ack_delay = 2;
        s0 = n_starts;
        tx_spur = 1'b1;
        tick();
        tx_spur = 1'b0;
        repeat (2) tick();
        check("spur_idle_no_start", n_starts - s0, 0);
        check("spur_idle_not_busy", int'(bus.o_busy), 0);
        start_frame(0);
        tx_spur = 1'b1;
        tick();
        tx_spur = 1'b0;
        wait_fd(2000);

        // Reset while waiting on byte 20, then restart from byte 0.
        ack_delay = 3;
        start_frame(1);
        wait_starts(20, 400);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        exp_q.delete();
        s0 = n_starts;
        f0 = n_fd;
        repeat (10) tick();
        check("reset_no_more_starts", n_starts - s0, 0);
        check("reset_no_frame_done", n_fd - f0, 0);
        start_frame(0);
        wait_fd(2000);

`ifdef FFT_TX_CHECKSUM_EN
        // bin0=00A5, bin1=005A: checksum byte A5^5A = FF.
        start_frame(2);
        wait_fd(2000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
